// File: rtl/stopwatch_count_scan.sv
// stopwatch_count_scan
// Four-digit BCD stopwatch (SS.hh) with start/stop/clear control and a
// time-multiplexed digit scan that feeds the seven-segment decoder.
// Optional lap/freeze feature: define STOPWATCH_LAP_EN to enable it.
// Without the macro the lap input is accepted but has no effect.
module stopwatch_count_scan #(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit_bcd,
  output logic [3:0] anode_n,
  output logic       dp_n,
  output logic       running,
  output logic       wrap
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               ss_prev_q, lap_prev_q;
  logic               ss_edge, lap_edge;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               tick;
  logic [3:0][3:0]    dig_q, dig_d;
  logic               wrap_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0][3:0]    show;
  logic [3:0]         digit_q;
  logic [3:0]         anode_q;
  logic               dp_q;
  logic               running_q;
  logic               wrap_q;

  // Rising-edge detection on the debounced control levels.
  assign ss_edge  = start_stop & ~ss_prev_q;
  assign lap_edge = lap & ~lap_prev_q;

  // Previous-level registers for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_prev_q  <= 1'b0;
      lap_prev_q <= 1'b0;
    end else begin
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: clear dominates and swallows any same-cycle edge.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (ss_edge) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Hundredth-second tick: last prescaler count while running.
  assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST);

  // Prescaler next value: counts in RUN, holds in PAUSE so a resume finishes
  // the partial period, and restarts from zero in IDLE or on clear.
  always_comb begin
    pre_d = pre_q;
    if (clear || (state_q == ST_IDLE)) begin
      pre_d = '0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // BCD ripple increment on tick; a carry out of the top digit is the wrap.
  always_comb begin
    logic carry;
    dig_d  = dig_q;
    wrap_d = 1'b0;
    carry  = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_d[i] = 4'd0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (clear) begin
      dig_d = '0;
    end else begin
      wrap_d = carry;
    end
  end

  // Count digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= '0;
    end else begin
      dig_q <= dig_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic            frozen_q, frozen_d;
  logic [3:0][3:0] disp_q, disp_d;

  // Lap freeze: a lap edge in RUN latches the live count for display; any lap
  // edge while frozen releases it; clear always releases it.
  always_comb begin
    frozen_d = frozen_q;
    disp_d   = disp_q;
    if (clear) begin
      frozen_d = 1'b0;
    end else if (lap_edge) begin
      if (frozen_q) begin
        frozen_d = 1'b0;
      end else if (state_q == ST_RUN) begin
        frozen_d = 1'b1;
        disp_d   = dig_q;
      end
    end
  end

  // Freeze flag and latched display digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frozen_q <= 1'b0;
      disp_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      disp_q   <= disp_d;
    end
  end

  assign show = frozen_q ? disp_q : dig_q;
`else
  logic unused_lap_edge;
  assign unused_lap_edge = lap_edge;
  assign show = dig_q;
`endif

  // Scan divider next value: free-running, advances the digit select at
  // terminal count.
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = sel_q + 2'd1;
    end
  end

  // Scan divider and digit select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      sel_q  <= 2'd0;
    end else begin
      scan_q <= scan_d;
      sel_q  <= sel_d;
    end
  end

  // Registered outputs; anode, digit and dp are all derived from the same
  // sel_q so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q   <= 4'b1110;
      digit_q   <= 4'd0;
      dp_q      <= 1'b1;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      anode_q   <= ~(4'b0001 << sel_q);
      digit_q   <= show[sel_q];
      dp_q      <= (sel_q != 2'd2);
      running_q <= (state_q == ST_RUN);
      wrap_q    <= wrap_d;
    end
  end

  assign digit_bcd = digit_q;
  assign anode_n   = anode_q;
  assign dp_n      = dp_q;
  assign running   = running_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_count_scan.sv
// Testbench for stopwatch_count_scan (TICK_DIV=4, SCAN_DIV=2).
// A behavioural model (elapsed hundredths as an integer, digit scan from the
// cycle count) predicts every output each cycle into a scoreboard queue;
// directed table rows and hand sequences check the spec's corner cases.
module tb_stopwatch_count_scan;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
`ifdef STOPWATCH_LAP_EN
  localparam int LAP_DISP = 5;
`else
  localparam int LAP_DISP = 25;
`endif

  // Clock and reset.
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] digit_bcd;
  logic [3:0] anode_n;
  logic       dp_n;
  logic       running;
  logic       wrap;

  always #5 clk = ~clk;

  stopwatch_count_scan #(
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .digit_bcd  (digit_bcd),
    .anode_n    (anode_n),
    .dp_n       (dp_n),
    .running    (running),
    .wrap       (wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {anode_n, digit_bcd, dp_n, running, wrap}
  logic [10:0] exp_q[$];

  // Model state
  int m_state, m_count, m_phase, m_n, m_frz;
  bit m_prev_ss, m_prev_lap, m_frozen;

  typedef struct {
    string name;
    logic  ss;
    logic  clr;
    logic  lp;
    int    n;
    logic  exp_run;
    bit    chk_disp;
    int    exp_disp;
  } vec_t;

  vec_t vecs[$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int sel_old, shown, div;
    bit ss_edge, tick;
    logic [3:0] e_an, e_dg;
    logic e_dp, e_run, e_wr;
    if (rst) begin
      m_state = M_IDLE; m_count = 0; m_phase = 0; m_n = 0; m_frz = 0;
      m_prev_ss = 0; m_prev_lap = 0; m_frozen = 0;
      exp_q.push_back({4'b1110, 4'd0, 1'b1, 1'b0, 1'b0});
      return;
    end
    sel_old = (m_n / SCAN_DIV) % 4;
    m_n++;
    shown = m_frozen ? m_frz : m_count;
    div = 1;
    repeat (sel_old) div = div * 10;
    e_dg  = 4'((shown / div) % 10);
    e_an  = ~(4'b0001 << sel_old);
    e_dp  = (sel_old != 2);
    e_run = (m_state == M_RUN);
    e_wr  = 1'b0;
    ss_edge   = start_stop && !m_prev_ss;
    m_prev_ss = start_stop;
    tick = (m_state == M_RUN) && (m_phase == TICK_DIV - 1);
`ifdef STOPWATCH_LAP_EN
    begin
      bit lap_edge;
      lap_edge   = lap && !m_prev_lap;
      m_prev_lap = lap;
      if (!clear && lap_edge) begin
        if (m_frozen) m_frozen = 0;
        else if (m_state == M_RUN) begin
          m_frozen = 1;
          m_frz    = m_count;
        end
      end
    end
`endif
    if (clear) begin
      m_state = M_IDLE; m_count = 0; m_phase = 0; m_frozen = 0;
    end else begin
      if (m_state == M_RUN) begin
        m_phase = (m_phase + 1) % TICK_DIV;
        if (tick) begin
          e_wr    = (m_count == 9999);
          m_count = (m_count + 1) % 10000;
        end
      end else if (m_state == M_IDLE) begin
        m_phase = 0;
      end
      if (ss_edge) begin
        if (m_state == M_RUN) m_state = M_PAUSE;
        else                  m_state = M_RUN;
      end
    end
    exp_q.push_back({e_an, e_dg, e_dp, e_run, e_wr});
  endtask

  task automatic check_outputs();
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check_eq("anode_n",   anode_n,   e[10:7]);
      check_eq("digit_bcd", digit_bcd, e[6:3]);
      check_eq("dp_n",      dp_n,      e[2]);
      check_eq("running",   running,   e[1]);
      check_eq("wrap",      wrap,      e[0]);
    end
  endtask

  // Driver: one clock cycle with the currently driven inputs.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Walk one full scan and assemble the displayed four-digit value.
  task automatic read_display(output int val);
    int d[4];
    int idx;
    d = '{0, 0, 0, 0};
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      step();
      idx = -1;
      case (anode_n)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) d[idx] = int'(digit_bcd);
    end
    val = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
  endtask

  function automatic void add(input string nm, input logic s, input logic c, input logic l,
                              input int n, input logic r, input bit cd, input int ed);
    vec_t v;
    v.name = nm; v.ss = s; v.clr = c; v.lp = l; v.n = n;
    v.exp_run = r; v.chk_disp = cd; v.exp_disp = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int val;

    //        name               ss clr lap  n  run chk disp
    add("start",             1, 0, 0,  1, 0, 0, 0);
    add("run40",             0, 0, 0, 40, 1, 0, 0);
    add("pause_a",           1, 0, 0,  1, 1, 0, 0);
    add("paused_a",          0, 0, 0,  4, 0, 1, 10);
    add("resume_a",          1, 0, 0,  1, 0, 0, 0);
    add("run1",              0, 0, 0,  1, 1, 0, 0);
    add("pause_b",           1, 0, 0,  1, 1, 0, 0);
    add("paused_b",          0, 0, 0, 20, 0, 1, 10);
    add("resume_b",          1, 0, 0,  1, 0, 0, 0);
    add("tick_after_resume", 0, 0, 0,  1, 1, 0, 0);
    add("pause_c",           1, 0, 0,  1, 1, 0, 0);
    add("paused_c",          0, 0, 0,  2, 0, 1, 11);
    add("clear_with_ss",     1, 1, 0,  1, 0, 0, 0);
    add("ss_held_after_clr", 1, 0, 0,  3, 0, 1, 0);
    add("release",           0, 0, 0,  2, 0, 0, 0);
    add("start2",            1, 0, 0,  1, 0, 0, 0);
    add("run3",              0, 0, 0,  3, 1, 0, 0);
    add("clear_on_tick",     0, 1, 0,  1, 1, 0, 0);
    add("after_clear",       0, 0, 0,  2, 0, 1, 0);
    add("start3",            1, 0, 0,  1, 0, 0, 0);
    add("to_0005",           0, 0, 0, 20, 1, 0, 0);
    add("lap_on",            0, 0, 1,  1, 1, 0, 0);
    add("run_20_ticks",      0, 0, 0, 79, 1, 0, 0);
    add("pause_lap",         1, 0, 0,  1, 1, 0, 0);
    add("frozen_disp",       0, 0, 0,  2, 0, 1, LAP_DISP);
    add("lap_off",           0, 0, 1,  1, 0, 0, 0);
    add("live_disp",         0, 0, 0,  2, 0, 1, 25);
    add("lap_in_pause",      0, 0, 1,  1, 0, 0, 0);
    add("lap_ignored",       0, 0, 0,  2, 0, 1, 25);
    add("clear_final",       0, 1, 0,  1, 0, 0, 0);
    add("cleared",           0, 0, 0,  1, 0, 1, 0);

    // Reset block
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    repeat (3) step();
    check_eq("reset_anode_n",   anode_n,   4'b1110);
    check_eq("reset_digit_bcd", digit_bcd, 4'd0);
    check_eq("reset_dp_n",      dp_n,      1'b1);
    check_eq("reset_running",   running,   1'b0);
    check_eq("reset_wrap",      wrap,      1'b0);
    rst = 1'b0;

    // Table-driven directed vectors
    foreach (vecs[i]) begin
      start_stop = vecs[i].ss;
      clear      = vecs[i].clr;
      lap        = vecs[i].lp;
      repeat (vecs[i].n) step();
      check_eq({vecs[i].name, "_running"}, running, vecs[i].exp_run);
      if (vecs[i].chk_disp) begin
        read_display(val);
        check_eq({vecs[i].name, "_display"}, val, vecs[i].exp_disp);
      end
    end

    // Wrap: 10000 ticks from 00.00
    start_stop = 1'b1; clear = 1'b0; lap = 1'b0;
    step();
    start_stop = 1'b0;
    repeat (40000 - 1) step();
    step();
    check_eq("wrap_pulse",        wrap,    1'b1);
    check_eq("wrap_running",      running, 1'b1);
    step();
    check_eq("wrap_one_cycle",    wrap,    1'b0);
    check_eq("wrap_still_running", running, 1'b1);
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    step();
    read_display(val);
    check_eq("wrap_display", val, 0);

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      start_stop = ($urandom_range(0, 15) == 0);
      clear      = ($urandom_range(0, 99) == 0);
      lap        = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
